alu_muldiv: RTL and testbench

Iterative multiply/divide unit that extends the single-cycle ALU datapath with the RV32M operation set: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It is parametrised in operand width and uses a valid/ready handshake on both sides, with flush support. It sits beside the ALU in the execute stage and stalls issue while busy. Results and a zero flag are returned with data-independent latency, except for the divide special cases.

---
 rtl/alu_muldiv_pkg.sv | 43 ++++
 rtl/alu_muldiv.sv | 163 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } muldiv_state_e;

    // MUL counts as signed: its low half is sign-agnostic, so signed magnitudes give the same bits.
    function automatic logic is_signed_a(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_e op);
        return op[2] && op[1];
    endfunction

    function automatic logic is_high(input muldiv_op_e op);
        return !op[2] && (op != OP_MUL);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider with valid/ready on both sides and flush.
// Handshakes: a transfer happens on an edge where valid and ready are both high; valid holds its payload until then.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLen    = 32,
    parameter int NOps    = 8,
    localparam int OpWidth = $clog2(NOps)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [OpWidth-1:0] op_i,
    input  logic [XLen-1:0]    a_i,
    input  logic [XLen-1:0]    b_i,
    input  logic               flush_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLen-1:0]    result_o,
    output logic               zero_o,
    output muldiv_state_e      state_o
);

    localparam int CntW = $clog2(XLen) + 1;

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q;
    muldiv_op_e      op_in;
    logic            sign_a_q, sign_b_q;
    logic [CntW-1:0] cnt_q;
    logic [XLen-1:0] hi_q, lo_q, opb_q;
    logic [XLen-1:0] result_q;
    logic            zero_q, valid_q;

    logic            accept, last_iter;
    logic            a_neg_in, b_neg_in, div_zero, overflow, special;
    logic [XLen-1:0] a_abs, b_abs, special_res;

    assign op_in     = muldiv_op_e'(op_i[2:0]);
    assign accept    = (state_q == S_IDLE) && valid_i && !flush_i;
    assign last_iter = (cnt_q == CntW'(XLen - 1));

    assign a_neg_in = is_signed_a(op_in) && a_i[XLen-1];
    assign b_neg_in = is_signed_b(op_in) && b_i[XLen-1];
    assign a_abs    = a_neg_in ? -a_i : a_i;
    assign b_abs    = b_neg_in ? -b_i : b_i;

    // Special cases bypass the iteration and land in DONE with a final result.
    assign div_zero = is_div(op_in) && (b_i == '0);
    assign overflow = is_div(op_in) && is_signed_b(op_in) &&
                      (a_i == {1'b1, {(XLen-1){1'b0}}}) && (b_i == '1);
    assign special  = div_zero || overflow;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem(op_in) ? a_i : '1;
        end else if (overflow) begin
            special_res = is_rem(op_in) ? '0 : a_i;
        end
    end

    // One iteration of either algorithm; hi/lo are shared between product and remainder/quotient.
    logic [XLen:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [XLen-1:0]   hi_n, lo_n;
    logic [2*XLen-1:0] prod, prod_fix;
    logic [XLen-1:0]   q_fix, r_fix, calc_res;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[XLen-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = !div_diff[XLen];
        hi_n      = mul_sum[XLen:1];
        lo_n      = {mul_sum[0], lo_q[XLen-1:1]};
        if (is_div(op_q)) begin
            hi_n = div_ge ? div_diff[XLen-1:0] : div_shift[XLen-1:0];
            lo_n = {lo_q[XLen-2:0], div_ge};
        end
    end

    always_comb begin
        prod     = {hi_n, lo_n};
        prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
        q_fix    = (sign_a_q ^ sign_b_q) ? -lo_n : lo_n;
        r_fix    = sign_a_q ? -hi_n : hi_n;
        if (is_div(op_q)) begin
            calc_res = is_rem(op_q) ? r_fix : q_fix;
        end else begin
            calc_res = is_high(op_q) ? prod_fix[2*XLen-1:XLen] : prod_fix[XLen-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (last_iter) state_d = S_DONE;
            S_DONE:  if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (valid_i) begin
                        op_q     <= op_in;
                        sign_a_q <= a_neg_in;
                        sign_b_q <= b_neg_in;
                        lo_q     <= a_abs;
                        opb_q    <= b_abs;
                        hi_q     <= '0;
                        cnt_q    <= '0;
                        if (special) begin
                            result_q <= special_res;
                            zero_q   <= (special_res == '0);
                            valid_q  <= 1'b1;
                        end
                    end
                    S_CALC: begin
                        hi_q  <= hi_n;
                        lo_q  <= lo_n;
                        cnt_q <= cnt_q + CntW'(1);
                        if (last_iter) begin
                            result_q <= calc_res;
                            zero_q   <= (calc_res == '0);
                            valid_q  <= 1'b1;
                        end
                    end
                    S_DONE: if (ready_i) valid_q <= 1'b0;
                    default: valid_q <= 1'b0;
                endcase
            end
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: hand-computed RV32M vectors, special cases, backpressure, flush and reset.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [2:0]    op_i = 3'b000;
    logic [31:0]   a_i = '0;
    logic [31:0]   b_i = '0;
    logic          flush_i = 1'b0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [31:0]   result_o;
    logic          zero_o;
    muldiv_state_e state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    alu_muldiv #(.XLen(32), .NOps(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .zero_o(zero_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one request and hold ready_i low for 'hold' cycles once the result shows up.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int hold);
        int lat;
        logic [31:0] exp;
        exp_q.push_back(exp_res);
        @(negedge clk_i);
        check({tag, " ready_o"}, 32'(ready_o), 32'd1);
        ready_i = (hold == 0);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        exp = exp_q.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result_o, exp);
        check({tag, " zero"}, 32'(zero_o), 32'(exp == 0));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                valid_i = 1'b1; op_i = 3'b011; a_i = 32'h1234; b_i = 32'h5678;
                @(posedge clk_i); #1;
                check({tag, " hold valid"}, 32'(valid_o), 32'd1);
                check({tag, " hold result"}, result_o, exp);
                check({tag, " hold zero"}, 32'(zero_o), 32'(exp == 0));
                check({tag, " hold ready_o"}, 32'(ready_o), 32'd0);
            end
            valid_i = 1'b0;
            ready_i = 1'b1;
        end
        @(posedge clk_i); #1;
        check({tag, " after valid"}, 32'(valid_o), 32'd0);
        check({tag, " after ready_o"}, 32'(ready_o), 32'd1);
    endtask

    // Start a divide, let it run 'iters' iterations, then abort with flush or reset.
    task automatic abort_op(input string tag, input int iters, input logic use_rst);
        logic seen;
        @(negedge clk_i);
        valid_i = 1'b1; op_i = 3'b101; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (iters) @(posedge clk_i);
        #1;
        check({tag, " in calc"}, 32'(state_o), 32'(S_CALC));
        if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; flush_i = 1'b0;
        check({tag, " ready_o"}, 32'(ready_o), 32'd1);
        check({tag, " valid_o"}, 32'(valid_o), 32'd0);
        if (use_rst) begin
            check({tag, " result reset"}, result_o, 32'd0);
            check({tag, " zero reset"}, 32'(zero_o), 32'd1);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            seen |= valid_o;
        end
        check({tag, " no late valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("reset ready_o", 32'(ready_o), 32'd1);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset zero", 32'(zero_o), 32'd1);
        check("reset state", 32'(state_o), 32'(S_IDLE));

        run_op("mul",     3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
        run_op("mul_lo0", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, 0);
        run_op("mulh",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
        run_op("mulh_n",  3'b001, 32'hFFFF_FFFF, 32'd5,        32'hFFFF_FFFF, 33, 0);
        run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
        run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 0);
        run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 0);
        run_op("divu",    3'b101, 32'd7,        32'd2,        32'd3,        33, 0);
        run_op("divu_max",3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33, 0);
        run_op("remu",    3'b111, 32'd6,        32'd3,        32'd0,        33, 0);
        run_op("div0",    3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1, 0);
        run_op("rem0",    3'b110, 32'd5,        32'd0,        32'd5,        1, 0);
        run_op("divu0",   3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1, 0);
        run_op("remu0",   3'b111, 32'd5,        32'd0,        32'd5,        1, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1, 0);

        run_op("bp_mul",  3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 5);
        run_op("bp_rem0", 3'b110, 32'd9,        32'd0,        32'd9,        1, 5);

        // A request presented together with flush in IDLE must be dropped.
        @(negedge clk_i);
        valid_i = 1'b1; flush_i = 1'b1; op_i = 3'b100; a_i = 32'd5; b_i = 32'd0;
        @(posedge clk_i); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        check("idle flush state", 32'(state_o), 32'(S_IDLE));
        @(posedge clk_i); #1;
        check("idle flush valid_o", 32'(valid_o), 32'd0);

        abort_op("flush", 10, 1'b0);
        abort_op("rst",   20, 1'b1);

        run_op("post_divu", 3'b101, 32'd7, 32'd2, 32'd3, 33, 0);
        run_op("post_mul",  3'b000, 32'd6, 32'd7, 32'd42, 33, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
